// File: rtl/decoder_pkg.sv
// Shared constants for the decoder round-robin scheduler.
package decoder_pkg;

  // Decoder input width and default decoder latency.
  localparam int unsigned DEC_CODE_W      = 7;
  localparam int unsigned DEC_LAT_DEFAULT = 2;

  // Latency counter width (supports DEC_LAT up to 15).
  localparam int unsigned LAT_W = 4;

  // FSM state encoding.
  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

endpackage : decoder_pkg

// File: rtl/decoder_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_any
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Scan requesters starting from ptr, wrapping explicitly modulo NUM_REQ.
  always_comb begin
    int unsigned          cand;
    logic [IDX_W-1:0]     cand_idx;
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(ptr) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!gnt_any && req[cand_idx]) begin
        gnt_any       = 1'b1;
        gnt_idx       = cand_idx;
        gnt[cand_idx] = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/decoder_rr_sched.sv
// Shares one decoder between NUM_REQ requesters, one transaction in flight at a time.
module decoder_rr_sched
  import decoder_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CODE_W  = DEC_CODE_W,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned DEC_LAT = DEC_LAT_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*CODE_W-1:0]    req_code,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [CODE_W-1:0]            dec_in,
  input  logic [OUT_W-1:0]             dec_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [OUT_W-1:0]             rsp_data,
  output logic                         busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [STATE_W-1:0] state_q,   state_nxt;
  logic [IDX_W-1:0]   rr_ptr_q,  rr_ptr_nxt;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_nxt;
  logic [CODE_W-1:0]  dec_in_nxt;
  logic               rsp_valid_nxt;
  logic [IDX_W-1:0]   rsp_id_nxt;
  logic [OUT_W-1:0]   rsp_data_nxt;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Grant is only offered while idle; it is the accept strobe for that cycle.
  assign req_ready = (state_q == ST_IDLE) ? gnt : '0;

  // Next-state and register-update logic for the scheduler FSM.
  always_comb begin
    state_nxt     = state_q;
    rr_ptr_nxt    = rr_ptr_q;
    lat_cnt_nxt   = lat_cnt_q;
    dec_in_nxt    = dec_in;
    rsp_valid_nxt = rsp_valid;
    rsp_id_nxt    = rsp_id;
    rsp_data_nxt  = rsp_data;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          dec_in_nxt  = req_code[32'(gnt_idx) * CODE_W +: CODE_W];
          rsp_id_nxt  = gnt_idx;
          lat_cnt_nxt = LAT_W'(DEC_LAT - 1);
          rr_ptr_nxt  = IDX_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
          state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == '0) begin
          rsp_data_nxt  = dec_out;
          rsp_valid_nxt = 1'b1;
          state_nxt     = ST_RESP;
        end else begin
          lat_cnt_nxt = lat_cnt_q - LAT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      lat_cnt_q <= '0;
      dec_in    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      rr_ptr_q  <= rr_ptr_nxt;
      lat_cnt_q <= lat_cnt_nxt;
      dec_in    <= dec_in_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_id    <= rsp_id_nxt;
      rsp_data  <= rsp_data_nxt;
      busy      <= (state_nxt != ST_IDLE);
    end
  end

endmodule : decoder_rr_sched

// File: tb/tb_decoder_rr_sched.sv
// Directed testbench for decoder_rr_sched with a one-register decoder model.
module tb_decoder_rr_sched;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [27:0] req_code;
  logic [3:0]  req_ready;
  logic [6:0]  dec_in;
  logic [7:0]  dec_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;

  int checks;
  int errors;

  // Codes per requester and hand-computed decoder outputs ({1'b1, ~code}).
  logic [6:0] code_tab [4];
  logic [7:0] data_tab [4];

  decoder_rr_sched #(
    .NUM_REQ (4),
    .CODE_W  (7),
    .OUT_W   (8),
    .DEC_LAT (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .dec_in    (dec_in),
    .dec_out   (dec_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Decoder model: registered inverse of the code with MSB set.
  always_ff @(posedge clock) dec_out <= {1'b1, ~dec_in};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction from IDLE with the given valid mask, expecting grant g.
  task automatic run_txn(input int g, input logic [3:0] vmask, input string tag);
    logic [3:0] exp_gnt;
    exp_gnt   = 4'(1 << g);
    req_valid = vmask;
    rsp_ready = 1'b1;
    #1;
    check({tag, " grant"}, 32'(req_ready), 32'(exp_gnt));
    tick();
    req_valid = 4'b0000;
    #1;
    check({tag, " dec_in"}, 32'(dec_in), 32'(code_tab[g]));
    check({tag, " busy_wait"}, 32'(busy), 32'd1);
    check({tag, " no_ready_wait"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, " no_rsp_early"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_id"}, 32'(rsp_id), 32'(g));
    check({tag, " rsp_data"}, 32'(rsp_data), 32'(data_tab[g]));
    tick();
    check({tag, " rsp_done"}, 32'(rsp_valid), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    clock       = 1'b0;
    reset       = 1'b1;
    req_valid   = 4'b0000;
    rsp_ready   = 1'b0;
    code_tab[0] = 7'b1111100; data_tab[0] = 8'h83;
    code_tab[1] = 7'h11;      data_tab[1] = 8'hEE;
    code_tab[2] = 7'h22;      data_tab[2] = 8'hDD;
    code_tab[3] = 7'h33;      data_tab[3] = 8'hCC;
    req_code    = {code_tab[3], code_tab[2], code_tab[1], code_tab[0]};

    // Reset values
    tick();
    tick();
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst busy",      32'(busy),      32'd0);
    check("rst dec_in",    32'(dec_in),    32'd0);
    check("rst rsp_id",    32'(rsp_id),    32'd0);
    check("rst rsp_data",  32'(rsp_data),  32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    tick();

    // 1: single request from requester 0
    run_txn(0, 4'b0001, "t1");

    // 2: all valid from a fresh pointer -> 0,1,2,3,0 at 4-cycle spacing
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_txn(0, 4'b1111, "t2a");
    run_txn(1, 4'b1111, "t2b");
    run_txn(2, 4'b1111, "t2c");
    run_txn(3, 4'b1111, "t2d");
    run_txn(0, 4'b1111, "t2e");

    // 3: backpressure on requester 1 (pointer is now 1)
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    #1;
    check("t3 grant", 32'(req_ready), 32'h2);
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3 hold valid", 32'(rsp_valid), 32'd1);
      check("t3 hold id",    32'(rsp_id),    32'd1);
      check("t3 hold data",  32'(rsp_data),  32'hEE);
      check("t3 hold busy",  32'(busy),      32'd1);
      check("t3 no ready",   32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    tick();
    check("t3 released",  32'(rsp_valid), 32'd0);
    check("t3 idle",      32'(busy),      32'd0);
    check("t3 next gnt",  32'(req_ready), 32'h4);
    req_valid = 4'b0000;

    // 4: move pointer to 3, then 4'b0110 wraps and skips to 1
    run_txn(2, 4'b0100, "t4a");
    run_txn(1, 4'b0110, "t4b");
    req_valid = 4'b1111;
    #1;
    check("t4 ptr2", 32'(req_ready), 32'h4);
    req_valid = 4'b0000;

    // 5: reset during WAIT drops the transaction and zeroes the pointer
    req_valid = 4'b1000;
    #1;
    check("t5 grant", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    check("t5 busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5 rst busy",     32'(busy),      32'd0);
    check("t5 rst valid",    32'(rsp_valid), 32'd0);
    check("t5 rst dec_in",   32'(dec_in),    32'd0);
    check("t5 rst rsp_id",   32'(rsp_id),    32'd0);
    check("t5 rst rsp_data", 32'(rsp_data),  32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5 no rsp", 32'(rsp_valid), 32'd0);
    end
    run_txn(0, 4'b1111, "t5ptr0");

    // 6: requester 2 arrives during WAIT of requester 0 (pointer is 1, only 0 valid)
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    check("t6 grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0100;
    #1;
    check("t6 wait1 ready",  32'(req_ready), 32'd0);
    check("t6 wait1 dec_in", 32'(dec_in),    32'(code_tab[0]));
    tick();
    check("t6 wait2 ready",  32'(req_ready), 32'd0);
    check("t6 wait2 dec_in", 32'(dec_in),    32'(code_tab[0]));
    tick();
    check("t6 resp id",      32'(rsp_id),    32'd0);
    check("t6 resp data",    32'(rsp_data),  32'h83);
    check("t6 resp ready",   32'(req_ready), 32'd0);
    tick();
    check("t6 idle grant2",  32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    #1;
    check("t6 dec_in2",      32'(dec_in),    32'(code_tab[2]));
    tick();
    tick();
    check("t6 rsp id2",      32'(rsp_id),    32'd2);
    check("t6 rsp data2",    32'(rsp_data),  32'hDD);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_decoder_rr_sched
